// File: rtl/cook_timer.sv
// cook_timer: MM:SS countdown engine with a 1 Hz tick and an 8-digit multiplexed display
// driver. Digit 5 is scanned blank so the controller can overlay the power level there.
module cook_timer #(
  parameter int unsigned TICK_DIV = 100_000_000,
  parameter int unsigned SCAN_DIV = 100_000
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       start,
  input  logic       pause,
  input  logic       stop,
  input  logic [6:0] min,
  input  logic [6:0] sec,
  output logic       done,
  output logic       running,
  output logic [7:0] an,
  output logic [7:0] dec_cat
);

  localparam int unsigned TW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam int unsigned SW = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
  localparam logic [TW-1:0] TICK_LAST = TW'(TICK_DIV - 1);
  localparam logic [SW-1:0] SCAN_LAST = SW'(SCAN_DIV - 1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    PAUSE = 2'd2
  } state_t;

  state_t        state_r;
  state_t        state_n_s;
  logic [6:0]    cnt_m_r;
  logic [6:0]    cnt_m_n_s;
  logic [6:0]    cnt_s_r;
  logic [6:0]    cnt_s_n_s;
  logic [TW-1:0] tick_r;
  logic [TW-1:0] tick_n_s;
  logic          done_r;
  logic          done_n_s;
  logic          running_r;
  logic [SW-1:0] scan_r;
  logic [2:0]    idx_r;
  logic [7:0]    an_r;
  logic [7:0]    an_n_s;
  logic [7:0]    cat_r;
  logic [7:0]    cat_n_s;
  logic [6:0]    min_clamp_s;
  logic [6:0]    sec_clamp_s;
  logic          preset_zero_s;
  logic          tick_wrap_s;
  logic          last_tick_s;

  function automatic logic [7:0] seg_code(input logic [6:0] d);
    case (d)
      7'd0:    seg_code = 8'h03;
      7'd1:    seg_code = 8'h9F;
      7'd2:    seg_code = 8'h25;
      7'd3:    seg_code = 8'h0D;
      7'd4:    seg_code = 8'h99;
      7'd5:    seg_code = 8'h49;
      7'd6:    seg_code = 8'h41;
      7'd7:    seg_code = 8'h1F;
      7'd8:    seg_code = 8'h01;
      7'd9:    seg_code = 8'h09;
      default: seg_code = 8'hFF;
    endcase
  endfunction

  assign min_clamp_s   = (min > 7'd99) ? 7'd99 : min;
  assign sec_clamp_s   = (sec > 7'd59) ? 7'd59 : sec;
  assign preset_zero_s = (min_clamp_s == 7'd0) && (sec_clamp_s == 7'd0);
  assign tick_wrap_s   = (tick_r == TICK_LAST);
  // The only decrement reaching 00:00 is from 00:01; m:00 borrows to (m-1):59.
  assign last_tick_s   = tick_wrap_s && (cnt_m_r == 7'd0) && (cnt_s_r == 7'd1);

  // Next-state, count and tick logic; stop outranks completion, completion outranks pause.
  always_comb begin
    state_n_s = state_r;
    cnt_m_n_s = cnt_m_r;
    cnt_s_n_s = cnt_s_r;
    tick_n_s  = tick_r;
    done_n_s  = 1'b0;
    case (state_r)
      IDLE: begin
        cnt_m_n_s = min_clamp_s;
        cnt_s_n_s = sec_clamp_s;
        tick_n_s  = {TW{1'b0}};
        if (start) begin
          if (preset_zero_s) begin
            done_n_s  = 1'b1;
            state_n_s = IDLE;
          end else begin
            state_n_s = RUN;
          end
        end else begin
          state_n_s = IDLE;
        end
      end
      RUN: begin
        if (stop) begin
          state_n_s = IDLE;
        end else begin
          if (tick_wrap_s) begin
            tick_n_s = {TW{1'b0}};
            if (cnt_s_r != 7'd0) begin
              cnt_s_n_s = cnt_s_r - 7'd1;
            end else if (cnt_m_r != 7'd0) begin
              cnt_m_n_s = cnt_m_r - 7'd1;
              cnt_s_n_s = 7'd59;
            end else begin
              cnt_s_n_s = cnt_s_r;
            end
          end else begin
            tick_n_s = tick_r + TW'(1);
          end
          if (last_tick_s) begin
            state_n_s = IDLE;
            done_n_s  = 1'b1;
          end else if (pause) begin
            state_n_s = PAUSE;
          end else begin
            state_n_s = RUN;
          end
        end
      end
      PAUSE: begin
        if (stop) begin
          state_n_s = IDLE;
        end else if (pause || start) begin
          state_n_s = RUN;
        end else begin
          state_n_s = PAUSE;
        end
      end
      default: begin
        state_n_s = IDLE;
      end
    endcase
  end

  // Countdown registers.
  always_ff @(posedge clock) begin
    if (reset) begin
      state_r   <= IDLE;
      cnt_m_r   <= 7'd0;
      cnt_s_r   <= 7'd0;
      tick_r    <= {TW{1'b0}};
      done_r    <= 1'b0;
      running_r <= 1'b0;
    end else begin
      state_r   <= state_n_s;
      cnt_m_r   <= cnt_m_n_s;
      cnt_s_r   <= cnt_s_n_s;
      tick_r    <= tick_n_s;
      done_r    <= done_n_s;
      running_r <= (state_n_s != IDLE);
    end
  end

  // Free-running digit scan, independent of countdown state.
  always_ff @(posedge clock) begin
    if (reset) begin
      scan_r <= {SW{1'b0}};
      idx_r  <= 3'd0;
    end else if (scan_r == SCAN_LAST) begin
      scan_r <= {SW{1'b0}};
      idx_r  <= idx_r + 3'd1;
    end else begin
      scan_r <= scan_r + SW'(1);
      idx_r  <= idx_r;
    end
  end

  // Digit select and BCD segment lookup for the current scan slot.
  always_comb begin
    an_n_s  = 8'hFF;
    cat_n_s = 8'hFF;
    case (idx_r)
      3'd0: begin
        an_n_s  = 8'hFE;
        cat_n_s = seg_code(cnt_s_r % 7'd10);
      end
      3'd1: begin
        an_n_s  = 8'hFD;
        cat_n_s = seg_code(cnt_s_r / 7'd10);
      end
      3'd2: begin
        an_n_s  = 8'hFB;
        cat_n_s = seg_code(cnt_m_r % 7'd10);
      end
      3'd3: begin
        an_n_s  = 8'hF7;
        cat_n_s = seg_code(cnt_m_r / 7'd10);
      end
      3'd5: begin
        an_n_s  = 8'hDF;
        cat_n_s = 8'hFF;
      end
      default: begin
        an_n_s  = 8'hFF;
        cat_n_s = 8'hFF;
      end
    endcase
  end

  // Registered display drive.
  always_ff @(posedge clock) begin
    if (reset) begin
      an_r  <= 8'hFF;
      cat_r <= 8'hFF;
    end else begin
      an_r  <= an_n_s;
      cat_r <= cat_n_s;
    end
  end

  assign done    = done_r;
  assign running = running_r;
  assign an      = an_r;
  assign dec_cat = cat_r;

endmodule
